// File: rtl/bc_poly_pkg.sv
// Shared definitions for the polynomial control block: state encoding,
// per-state control words and run length.
package bc_poly_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_B    = 4'd1,
        S_C    = 4'd2,
        S_D    = 4'd3,
        S_E    = 4'd4,
        S_F    = 4'd5,
        S_G    = 4'd6,
        S_H    = 4'd7,
        S_I    = 4'd8,
        S_J    = 4'd9,
        S_K    = 4'd10,
        S_DONE = 4'd11
    } state_e;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
    } ctrl_t;

    // Layout: m0 m1 m2 lx ls lh h
    localparam ctrl_t CW_IDLE = 10'b00_00_00_0000;
    localparam ctrl_t CW_B    = 10'b00_00_00_1001;
    localparam ctrl_t CW_C    = 10'b00_00_00_1011;
    localparam ctrl_t CW_D    = 10'b10_10_11_1001;
    localparam ctrl_t CW_E    = 10'b10_10_11_1011;
    localparam ctrl_t CW_F    = 10'b01_10_00_1001;
    localparam ctrl_t CW_G    = 10'b01_10_00_1101;
    localparam ctrl_t CW_H    = 10'b00_11_01_1000;
    localparam ctrl_t CW_I    = 10'b00_11_01_1010;
    localparam ctrl_t CW_J    = 10'b11_10_11_1000;
    localparam ctrl_t CW_K    = 10'b11_10_11_1100;
    localparam ctrl_t CW_DONE = 10'b00_00_00_0000;

    localparam int RUN_LEN = 10;

endpackage

// File: rtl/bc_polinomio_decode.sv
// Combinational state to control-word lookup for the polynomial
// control block.
module bc_polinomio_decode
    import bc_poly_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = CW_IDLE;
        unique case (state_i)
            S_IDLE: ctrl_o = CW_IDLE;
            S_B:    ctrl_o = CW_B;
            S_C:    ctrl_o = CW_C;
            S_D:    ctrl_o = CW_D;
            S_E:    ctrl_o = CW_E;
            S_F:    ctrl_o = CW_F;
            S_G:    ctrl_o = CW_G;
            S_H:    ctrl_o = CW_H;
            S_I:    ctrl_o = CW_I;
            S_J:    ctrl_o = CW_J;
            S_K:    ctrl_o = CW_K;
            S_DONE: ctrl_o = CW_DONE;
            default: ctrl_o = CW_IDLE;
        endcase
    end

endmodule

// File: rtl/bc_polinomio.sv
// Moore control FSM sequencing the A*X^2 + B*X + C datapath,
// with start/busy/done handshake.
module bc_polinomio
    import bc_poly_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       lx,
    output logic       ls,
    output logic       lh,
    output logic       h
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE: state_d = start ? S_B : S_IDLE;
            S_B:    state_d = S_C;
            S_C:    state_d = S_D;
            S_D:    state_d = S_E;
            S_E:    state_d = S_F;
            S_F:    state_d = S_G;
            S_G:    state_d = S_H;
            S_H:    state_d = S_I;
            S_I:    state_d = S_J;
            S_J:    state_d = S_K;
            S_K:    state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    bc_polinomio_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_comb begin
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
        done = (state_q == S_DONE);
        m0   = ctrl.m0;
        m1   = ctrl.m1;
        m2   = ctrl.m2;
        lx   = ctrl.lx;
        ls   = ctrl.ls;
        lh   = ctrl.lh;
        h    = ctrl.h;
    end

endmodule

// File: tb/tb_bc_polinomio.sv
// Scoreboard bench for bc_polinomio: stimulus queues expected
// per-cycle output words, a monitor compares them on the falling edge.
module tb_bc_polinomio;
    import bc_poly_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;

    typedef struct {
        int          cyc;
        logic [11:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   errors;
    int   checks;
    logic [9:0] run_words [10];

    bc_polinomio dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .lx    (lx),
        .ls    (ls),
        .lh    (lh),
        .h     (h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] outs();
        return {busy, done, m0, m1, m2, lx, ls, lh, h};
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %b expected %b",
                     name, cyc, act, req);
        end
    endtask

    // Monitor: DUT presents a word whenever busy or done is high.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1 || done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output @cyc %0d: got %b",
                         cyc, outs());
            end else begin
                e = exp_q.pop_front();
                check("ctrl_word", outs(), e.word);
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL word_timing: got cyc %0d expected %0d",
                             cyc, e.cyc);
                end
            end
        end else begin
            check("idle_zero", outs(), 12'd0);
        end
    end

    task automatic push_run(int base);
        exp_t e;
        for (int k = 0; k < RUN_LEN; k++) begin
            e.cyc  = base + 1 + k;
            e.word = {2'b10, run_words[k]};
            exp_q.push_back(e);
        end
        e.cyc  = base + RUN_LEN + 1;
        e.word = 12'b01_00_00_00_0000;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int n);
        do tick(); while (cyc < n);
    endtask

    task automatic run_one(output int base);
        tick();
        start = 1'b1;
        base  = cyc;
        push_run(base);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        errors = 0;
        checks = 0;
        run_words[0] = 10'b00_00_00_1001;
        run_words[1] = 10'b00_00_00_1011;
        run_words[2] = 10'b10_10_11_1001;
        run_words[3] = 10'b10_10_11_1011;
        run_words[4] = 10'b01_10_00_1001;
        run_words[5] = 10'b01_10_00_1101;
        run_words[6] = 10'b00_11_01_1000;
        run_words[7] = 10'b00_11_01_1010;
        run_words[8] = 10'b11_10_11_1000;
        run_words[9] = 10'b11_10_11_1100;

        rst   = 1'b1;
        start = 1'b1;
        #1;
        check("reset_state", outs(), 12'd0);
        repeat (2) tick();
        start = 1'b0;
        rst   = 1'b0;

        // Idle stability
        repeat (50) tick();

        // Single run
        run_one(base);
        wait_cyc(base + 14);

        // Pulses in D and DONE must be dropped
        run_one(base);
        wait_cyc(base + 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc(base + RUN_LEN + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();

        // Back-to-back with start held high
        tick();
        start = 1'b1;
        base  = cyc;
        push_run(base);
        push_run(base + 12);
        push_run(base + 24);
        repeat (30) tick();
        start = 1'b0;
        wait_cyc(base + 40);

        // Reset during F abandons the run
        run_one(base);
        wait_cyc(base + 5);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", outs(), 12'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (15) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words never seen",
                     exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
